intr_ctrl: RTL and testbench
============================

Name: intr_ctrl

Overview:
- Interrupt sequencer; drives the bank-select input `intr_en` of the condition-code register, i.e. it is the producer side of that interface.
- Detects an external interrupt, holds fetch and drains the pipeline, then pushes the return PC through a req/ack handshake.
- Redirects fetch to the interrupt vector and keeps the ISR flag bank selected until RTI retires.
- Sits between the fetch stage, the stack/memory port and the CCR.

Parameters:
- PC_W, 32, width of PC and return address
- VEC_ADDR, 32'h0000_0004, ISR entry address loaded into PC
- DRAIN_CYCLES, 4, cycles fetch is held so in-flight instructions retire (must be >= 1)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- intr_req  in  1  level interrupt request, already synchronised; a rising edge requests service
- pc_next  in  PC_W  address of next unfetched instruction (return address)
- rti_done  in  1  one-cycle pulse when an RTI retires
- push_ack  in  1  memory port accepted the push
- fetch_hold  out  1  freeze PC and inject bubbles into fetch
- push_req  out  1  request to push push_data onto the stack
- push_data  out  PC_W  saved return PC
- pc_load  out  1  one-cycle pulse: fetch loads pc_load_addr
- pc_load_addr  out  PC_W  equals VEC_ADDR
- intr_en  out  1  CCR bank select; 1 = ISR flag bank
- intr_ack  out  1  one-cycle pulse on ISR entry

Behaviour:
- Reset (async, rst=1) forces:
  - state=IDLE
  - all outputs 0; pc_load_addr=VEC_ADDR constant
  - ret_pc=0, pending=0, drain_cnt=0, req_d=0
- Edge detect: req_d registers intr_req; edge = intr_req & ~req_d. A level held high produces one edge only.
- IDLE:
  - On edge or pending=1: go to HOLD, latch ret_pc<=pc_next, drain_cnt<=DRAIN_CYCLES-1, clear pending.
  - fetch_hold rises the same edge, so it is registered and visible the next cycle.
- HOLD:
  - fetch_hold=1.
  - If drain_cnt==0, go to PUSH; otherwise drain_cnt decrements.
  - Total fetch_hold cycles before PUSH = DRAIN_CYCLES.
- PUSH:
  - fetch_hold=1, push_req=1, push_data=ret_pc.
  - push_req stays high and push_data stays stable until a cycle with push_ack=1.
  - On ack, go to VECTOR. Ack in the first PUSH cycle is legal.
- VECTOR (exactly one cycle):
  - pc_load=1, intr_ack=1, fetch_hold=1.
  - Next state ISR; intr_en<=1 on the same edge that the PC loads VEC_ADDR.
  - Effect: the first ISR instruction writes the ISR flag bank, and all drained instructions wrote the normal bank.
- ISR:
  - intr_en=1, fetch_hold=0.
  - No nesting: an edge sets pending=1.
  - On rti_done, go to IDLE; intr_en<=0 on that edge.
- rti_done outside ISR is ignored; no state or output change.
- Simultaneous edge and rti_done in ISR: pending<=1 and exit to IDLE. IDLE then starts a new HOLD on the next cycle, with intr_en low for exactly one cycle.
- Edge during HOLD/PUSH/VECTOR: sets pending, serviced after the current ISR returns.
- Reset mid-sequence (any state) returns to IDLE immediately:
  - intr_en=0 and push_req drops asynchronously.
  - Any in-flight push is abandoned.
- All outputs are registered or decoded from the registered state only; no combinational path from inputs to outputs.
- Widths: ret_pc and push_data are PC_W. drain_cnt is $clog2(DRAIN_CYCLES+1) bits and never underflows.

Decomposition:
- Shared package intr_pkg holds:
  - state encoding: IDLE=3'd0, HOLD=3'd1, PUSH=3'd2, VECTOR=3'd3, ISR=3'd4
  - default VEC_ADDR and DRAIN_CYCLES constants, also used by the fetch unit and the testbench
- One natural sub-module: intr_edge_pend, holding the edge detector plus the pending latch (set on edge while busy, clear on HOLD entry).
- FSM and datapath stay in intr_ctrl.

Test Plan:
- Basic entry:
  - Stimulus: pc_next=32'h0000_0040, intr_req 0->1, push_ack tied 1, DRAIN_CYCLES=4.
  - Response: fetch_hold high 4 cycles then PUSH with push_data=32'h40; next cycle pc_load=1, pc_load_addr=32'h4, intr_ack=1; intr_en=1 from the following cycle.
- Push backpressure:
  - Stimulus: push_ack low for 3 PUSH cycles.
  - Response: push_req held and push_data stable at 32'h40 for 4 cycles; VECTOR occurs only after ack.
- Return:
  - Stimulus: rti_done pulse in ISR.
  - Response: intr_en=0 the next cycle, state IDLE; a second rti_done in IDLE causes no change.
- Pending:
  - Stimulus: second intr_req edge during ISR, then rti_done.
  - Response: exactly one extra HOLD/PUSH/VECTOR sequence; intr_en low for exactly 1 cycle between ISRs.
- Level hold:
  - Stimulus: intr_req held high across entry and return.
  - Response: only one ISR entry.
- Async reset:
  - Stimulus: rst=1 mid-PUSH, between clock edges.
  - Response: push_req, fetch_hold and intr_en go 0 immediately; after release with intr_req low, the block stays IDLE.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt sequencer, fetch unit and benches.
package intr_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    PUSH   = 3'd2,
    VECTOR = 3'd3,
    ISR    = 3'd4
  } intr_state_e;

  localparam logic [31:0] DEF_VEC_ADDR     = 32'h0000_0004;
  localparam int          DEF_DRAIN_CYCLES = 4;

endpackage

// File: rtl/intr_ctrl_edge_pend.sv
// Rising-edge detector for the interrupt request plus the pending latch that
// remembers a request arriving while the sequencer is busy.
module intr_edge_pend
  import intr_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic intr_req,
  input  logic busy,
  input  logic clr,
  output logic req_edge,
  output logic pending
);

  logic req_d;

  assign req_edge = intr_req & ~req_d;

  // Delay the request level by one cycle for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_d <= 1'b0;
    else     req_d <= intr_req;
  end

  // Set on an edge while busy; cleared when a new HOLD sequence starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   pending <= 1'b0;
    else if (clr)              pending <= 1'b0;
    else if (req_edge && busy) pending <= 1'b1;
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt sequencer: holds fetch to drain the pipeline, pushes the return
// PC, redirects fetch to the vector and selects the ISR flag bank until RTI.
//
// state  | meaning
// IDLE   | waiting for a request edge or a pending request
// HOLD   | fetch frozen while in-flight instructions retire
// PUSH   | return PC offered to the stack port until acknowledged
// VECTOR | one cycle: PC loads the vector address
// ISR    | handler running on the ISR flag bank; exits on rti_done
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] VEC_ADDR     = PC_W'(DEF_VEC_ADDR),
  parameter int              DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            intr_req,
  input  logic [PC_W-1:0] pc_next,
  input  logic            rti_done,
  input  logic            push_ack,
  output logic            fetch_hold,
  output logic            push_req,
  output logic [PC_W-1:0] push_data,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_load_addr,
  output logic            intr_en,
  output logic            intr_ack
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  intr_state_e     state, state_nxt;
  logic [CNT_W-1:0] drain_cnt;
  logic [PC_W-1:0]  ret_pc;
  logic             req_edge, pending, start;

  assign start = (state == IDLE) && (req_edge || pending);

  intr_edge_pend u_edge_pend (
    .clk      (clk),
    .rst      (rst),
    .intr_req (intr_req),
    .busy     (state != IDLE),
    .clr      (start),
    .req_edge (req_edge),
    .pending  (pending)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and outputs decoded from the registered state only.
  always_comb begin
    state_nxt  = state;
    fetch_hold = 1'b0;
    push_req   = 1'b0;
    pc_load    = 1'b0;
    intr_ack   = 1'b0;
    intr_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = HOLD;
      end
      HOLD: begin
        fetch_hold = 1'b1;
        if (drain_cnt == '0) state_nxt = PUSH;
      end
      PUSH: begin
        fetch_hold = 1'b1;
        push_req   = 1'b1;
        if (push_ack) state_nxt = VECTOR;
      end
      VECTOR: begin
        fetch_hold = 1'b1;
        pc_load    = 1'b1;
        intr_ack   = 1'b1;
        state_nxt  = ISR;
      end
      ISR: begin
        intr_en = 1'b1;
        if (rti_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Return-PC capture and drain countdown; the counter stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_pc    <= '0;
      drain_cnt <= '0;
    end else if (start) begin
      ret_pc    <= pc_next;
      drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
    end else if (state == HOLD && drain_cnt != '0) begin
      drain_cnt <= drain_cnt - CNT_W'(1);
    end
  end

  assign push_data    = ret_pc;
  assign pc_load_addr = VEC_ADDR;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: entry, backpressure, return, pending,
// level hold and asynchronous reset.
module tb_intr_ctrl;
  import intr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        intr_req;
  logic [31:0] pc_next;
  logic        rti_done;
  logic        push_ack;
  logic        fetch_hold, push_req, pc_load, intr_en, intr_ack;
  logic [31:0] push_data, pc_load_addr;

  int checks = 0;
  int errors = 0;

  intr_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .intr_req     (intr_req),
    .pc_next      (pc_next),
    .rti_done     (rti_done),
    .push_ack     (push_ack),
    .fetch_hold   (fetch_hold),
    .push_req     (push_req),
    .push_data    (push_data),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .intr_en      (intr_en),
    .intr_ack     (intr_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs packed as {fetch_hold, push_req, pc_load, intr_ack, intr_en}.
  task automatic check_ctl(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, fetch_hold, push_req, pc_load, intr_ack, intr_en}, {27'd0, exp});
  endtask

  initial begin
    rst = 1'b1; intr_req = 1'b0; pc_next = 32'h40; rti_done = 1'b0; push_ack = 1'b1;
    #12;
    check_ctl("reset_ctl", 5'b00000);
    check("reset_push_data", push_data, 32'h0);
    check("reset_vec", pc_load_addr, 32'h4);
    rst = 1'b0;
    tick();
    check_ctl("idle_ctl", 5'b00000);

    // Basic entry with intr_req then held high (level hold).
    intr_req = 1'b1;
    tick();
    check_ctl("hold1", 5'b10000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_ctl("hold_n", 5'b10000);
    end
    tick();
    check_ctl("push", 5'b11000);
    check("push_data", push_data, 32'h40);
    tick();
    check_ctl("vector", 5'b10110);
    check("vec_addr", pc_load_addr, 32'h4);
    tick();
    check_ctl("isr", 5'b00001);
    tick();
    check_ctl("isr2", 5'b00001);

    // Return while intr_req still high: no re-entry.
    rti_done = 1'b1;
    tick();
    rti_done = 1'b0;
    check_ctl("ret_idle", 5'b00000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_ctl("level_no_reentry", 5'b00000);
    end
    rti_done = 1'b1;
    tick();
    rti_done = 1'b0;
    check_ctl("rti_in_idle", 5'b00000);
    tick();
    check_ctl("rti_in_idle2", 5'b00000);

    // Backpressure: push_ack low for three PUSH cycles.
    intr_req = 1'b0;
    push_ack = 1'b0;
    tick();
    intr_req = 1'b1;
    tick();
    check_ctl("bp_hold1", 5'b10000);
    pc_next = 32'h80;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_ctl("bp_hold_n", 5'b10000);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      check_ctl("bp_push", 5'b11000);
      check("bp_push_data", push_data, 32'h40);
    end
    push_ack = 1'b1;
    tick();
    check_ctl("bp_vector", 5'b10110);
    tick();
    check_ctl("bp_isr", 5'b00001);

    // Pending: new edge during ISR is serviced after return.
    intr_req = 1'b0;
    tick();
    intr_req = 1'b1;
    tick();
    check_ctl("pend_isr", 5'b00001);
    pc_next = 32'h100;
    rti_done = 1'b1;
    tick();
    rti_done = 1'b0;
    check_ctl("pend_gap", 5'b00000);
    tick();
    check_ctl("pend_hold1", 5'b10000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_ctl("pend_hold_n", 5'b10000);
    end
    tick();
    check_ctl("pend_push", 5'b11000);
    check("pend_push_data", push_data, 32'h100);
    tick();
    check_ctl("pend_vector", 5'b10110);
    tick();
    check_ctl("pend_isr2", 5'b00001);
    intr_req = 1'b0;
    rti_done = 1'b1;
    tick();
    rti_done = 1'b0;
    check_ctl("pend_ret", 5'b00000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_ctl("pend_once", 5'b00000);
    end

    // Async reset mid-PUSH.
    push_ack = 1'b0;
    intr_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_ctl("ar_push", 5'b11000);
    #2;
    rst = 1'b1;
    #1;
    check_ctl("ar_async", 5'b00000);
    intr_req = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_ctl("ar_stay_idle", 5'b00000);
    end
    check("ar_push_data", push_data, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
